// File: rtl/qmfir_uart_pkg.sv
// Shared definitions for the QM-FIR UART register/memory access protocol.
// Used by the host-side master and the chip-side responder.
package qmfir_uart_pkg;

    localparam int ADDR_W        = 14;
    localparam int DATA_W        = 24;
    localparam int DATA_BYTES    = 3;
    localparam int BYTE0_WR_BIT  = 7;
    localparam int BYTE0_MEM_BIT = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD_HI,
        ST_CMD_LO,
        ST_WD2,
        ST_WD1,
        ST_WD0,
        ST_RD2,
        ST_RD1,
        ST_RD0,
        ST_DONE
    } state_e;

    // Command byte 0 carries the access kind above the upper address bits.
    function automatic logic [7:0] cmd_byte0(
        input logic              wr,
        input logic              mem,
        input logic [ADDR_W-1:0] addr
    );
        logic [7:0] b;
        b                = {2'b00, addr[ADDR_W-1:8]};
        b[BYTE0_WR_BIT]  = wr;
        b[BYTE0_MEM_BIT] = mem;
        return b;
    endfunction

endpackage

// File: rtl/uart_rsp_timer.sv
// Read-response timeout counter: clear/increment with a terminal-count flag
// that fires on the increment that would reach TO_CYC-1.
module uart_rsp_timer #(
    parameter int          TO_W   = 20,
    parameter int unsigned TO_CYC = 20'hFFFFF
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [TO_W-1:0] TC_VAL =
        (TO_CYC >= 2) ? TO_W'(TO_CYC - 2) : '0;

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = inc_i && ((TO_CYC < 2) || (cnt_q == TC_VAL));

endmodule

// File: rtl/uart_host_master.sv
// Host-side initiator: serialises a register/memory access into UART command
// bytes and collects the 3-byte read response from the RX FIFO.
module uart_host_master
    import qmfir_uart_pkg::*;
#(
    parameter int          TO_W   = 20,
    parameter int unsigned TO_CYC = 20'hFFFFF
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_mem,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_we,
    input  logic              tx_full,
    input  logic [7:0]        rx_data,
    output logic              rx_re,
    input  logic              rx_empty
);

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic              mem_q, mem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              in_rx, to_tc, to_hit;

    assign in_rx = (state_q == ST_RD2) || (state_q == ST_RD1)
                || (state_q == ST_RD0);

    // Restart the wait window on entry to the RX states and on every byte.
    uart_rsp_timer #(
        .TO_W   (TO_W),
        .TO_CYC (TO_CYC)
    ) u_timer (
        .clk    (clk),
        .arst_n (arst_n),
        .clr_i  (~in_rx | ~rx_empty),
        .inc_i  (in_rx & rx_empty),
        .tc_o   (to_tc)
    );

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        mem_d       = mem_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tx_data     = 8'h00;
        tx_we       = 1'b0;
        rx_re       = 1'b0;
        to_hit      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rx_re = ~rx_empty;
                if (req_valid) begin
                    wr_d    = req_wr;
                    mem_d   = req_mem;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    state_d = ST_CMD_HI;
                end
            end
            ST_CMD_HI: begin
                tx_data = cmd_byte0(wr_q, mem_q, addr_q);
                tx_we   = ~tx_full;
                if (!tx_full) state_d = ST_CMD_LO;
            end
            ST_CMD_LO: begin
                tx_data = addr_q[7:0];
                tx_we   = ~tx_full;
                if (!tx_full) state_d = wr_q ? ST_WD2 : ST_RD2;
            end
            ST_WD2: begin
                tx_data = wdata_q[23:16];
                tx_we   = ~tx_full;
                if (!tx_full) state_d = ST_WD1;
            end
            ST_WD1: begin
                tx_data = wdata_q[15:8];
                tx_we   = ~tx_full;
                if (!tx_full) state_d = ST_WD0;
            end
            ST_WD0: begin
                tx_data = wdata_q[7:0];
                tx_we   = ~tx_full;
                if (!tx_full) state_d = ST_DONE;
            end
            ST_RD2: begin
                rx_re = ~rx_empty;
                if (!rx_empty) begin
                    rdata_d[23:16] = rx_data;
                    state_d        = ST_RD1;
                end else if (to_tc) begin
                    to_hit  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD1: begin
                rx_re = ~rx_empty;
                if (!rx_empty) begin
                    rdata_d[15:8] = rx_data;
                    state_d       = ST_RD0;
                end else if (to_tc) begin
                    to_hit  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD0: begin
                rx_re = ~rx_empty;
                if (!rx_empty) begin
                    rdata_d[7:0] = rx_data;
                    state_d      = ST_DONE;
                end else if (to_tc) begin
                    to_hit  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (to_hit) rdata_d = '0;
        // Response registers load on entry to DONE so they are valid there.
        if (state_d == ST_DONE) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = to_hit;
            rsp_rdata_d = rdata_d;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            mem_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            mem_q       <= mem_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uart_host_master.sv
// Scoreboard bench for uart_host_master with FIFO models on both byte sides.
// Expected bytes and responses are queued at issue time and checked by monitor.
module tb_uart_host_master;

    logic        clk;
    logic        arst_n;
    logic        req_valid, req_ready, req_wr, req_mem;
    logic [13:0] req_addr;
    logic [23:0] req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [23:0] rsp_rdata;
    logic [7:0]  tx_data, rx_data;
    logic        tx_we, tx_full, rx_re, rx_empty;

    logic        bp_force, bp_rand, rnd_bit;
    assign tx_full = bp_force | (bp_rand & rnd_bit);

    uart_host_master #(.TO_W(20), .TO_CYC(16)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_mem   (req_mem),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .tx_data   (tx_data),
        .tx_we     (tx_we),
        .tx_full   (tx_full),
        .rx_data   (rx_data),
        .rx_re     (rx_re),
        .rx_empty  (rx_empty)
    );

    typedef struct {
        logic [23:0] rdata;
        logic        err;
        int          lat;
        int          pops;
        int          acc;
    } rsp_t;

    rsp_t       exp_rsp[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_pops = 0;
    int idle_pops = 0;
    bit pop_pend = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 2) == 0);
    end

    // RX FIFO model: pop decided at the previous negedge, applied after the edge.
    always @(posedge clk) begin
        #2;
        if (pop_pend && rx_q.size() > 0) void'(rx_q.pop_front());
        pop_pend = 0;
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (!arst_n) begin
            busy_pops = 0;
            pop_pend  = 0;
        end else begin
            if (tx_we || rx_re) chk("tx_rx_exclusive", 32'(tx_we & rx_re), 0);
            if (tx_full) chk("no_push_while_full", 32'(tx_we), 0);
            if (tx_we) begin
                if (exp_tx.size() == 0) begin
                    chk("unexpected_tx_byte", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                end
            end
            pop_pend = rx_re && !rx_empty;
            if (pop_pend && busy) busy_pops++;
            if (pop_pend && !busy) idle_pops++;
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 0);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rx_pops", 32'(busy_pops), 32'(e.pops));
                    if (e.lat >= 0) chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
                busy_pops = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp_cmd(input logic wr, input logic mem,
                                input logic [13:0] addr, input logic [23:0] wd);
        exp_tx.push_back(8'((32'(wr) << 7) | (32'(mem) << 6) | (32'(addr) >> 8)));
        exp_tx.push_back(8'(addr % 256));
        if (wr) begin
            for (int i = 0; i < 3; i++) exp_tx.push_back(8'(wd >> (16 - 8 * i)));
        end
    endtask

    task automatic issue(input logic wr, input logic mem, input logic [13:0] addr,
                         input logic [23:0] wd, input int nrx, input logic [23:0] rxv,
                         input int gapmax, input int stall_at, input int lat);
        rsp_t e;
        int   g;
        g = 0;
        while (!req_ready && g < 100) begin
            step();
            g++;
        end
        chk("req_ready_before_issue", 32'(req_ready), 1);
        if (!req_ready) return;
        req_wr    = wr;
        req_mem   = mem;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        push_exp_cmd(wr, mem, addr, wd);
        e.err   = !wr && (nrx < 3);
        e.rdata = (wr || e.err) ? 24'h0 : rxv;
        e.pops  = wr ? 0 : nrx;
        e.lat   = lat;
        e.acc   = cyc;
        exp_rsp.push_back(e);
        step();
        req_valid = 1'b0;
        req_wdata = $urandom();
        if (!wr) begin
            for (int i = 0; i < nrx; i++) begin
                if (i > 0 && gapmax > 0) begin
                    g = $urandom_range(0, gapmax);
                    repeat (g) step();
                end
                rx_q.push_back(8'(rxv >> (16 - 8 * i)));
            end
        end
        if (stall_at > 0) begin
            repeat (stall_at - 1) step();
            bp_force = 1'b1;
            repeat (4) step();
            bp_force = 1'b0;
        end
        g = 0;
        while (exp_rsp.size() != 0 && g < 300) begin
            step();
            g++;
        end
        chk("rsp_arrived", 32'(exp_rsp.size()), 0);
        if (exp_rsp.size() != 0) begin
            exp_rsp.delete();
            exp_tx.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        logic [13:0] a;
        arst_n    = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_mem   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        bp_force  = 1'b0;
        bp_rand   = 1'b0;
        rx_empty  = 1'b1;
        rx_data   = 8'h00;
        #3;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_tx_we", 32'(tx_we), 0);
        chk("rst_rx_re", 32'(rx_re), 0);
        repeat (2) step();
        arst_n = 1'b1;
        step();

        // write, no backpressure: C1 23 A5 B6 C7, response at T+6
        issue(1'b1, 1'b1, 14'h0123, 24'hA5B6C7, 0, 24'h0, 0, 0, 6);
        // register read from the top address, all bytes available
        issue(1'b0, 1'b0, 14'h3FFF, 24'h0, 3, 24'h123456, 0, 0, 6);
        // four stalled cycles while the middle data byte is offered
        issue(1'b1, 1'b0, 14'h2A55, 24'h0F1E2D, 0, 24'h0, 0, 4, 10);
        // only one response byte: abort 16 cycles after that pop
        issue(1'b0, 1'b1, 14'h1234, 24'h0, 1, 24'h9A0000, 0, 0, 19);
        chk("ready_after_timeout", 32'(req_ready), 1);

        // stale bytes are flushed while idle
        base = idle_pops;
        rx_q.push_back(8'hEE);
        rx_q.push_back(8'hDD);
        repeat (4) step();
        chk("stale_pops", 32'(idle_pops - base), 2);
        chk("stale_fifo_empty", 32'(rx_q.size()), 0);
        issue(1'b0, 1'b1, 14'h0042, 24'h0, 3, 24'hC0FFEE, 0, 0, 6);

        // reset while waiting in RD1 aborts without a response
        a         = 14'h0555;
        req_wr    = 1'b0;
        req_mem   = 1'b1;
        req_addr  = a;
        req_valid = 1'b1;
        push_exp_cmd(1'b0, 1'b1, a, 24'h0);
        step();
        req_valid = 1'b0;
        rx_q.push_back(8'h77);
        repeat (3) step();
        chk("in_rd1_busy", 32'(busy), 1);
        arst_n = 1'b0;
        #2;
        chk("arst_req_ready", 32'(req_ready), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("arst_rsp_err", 32'(rsp_err), 0);
        chk("arst_tx_we", 32'(tx_we), 0);
        chk("arst_rx_re", 32'(rx_re), 0);
        chk("arst_cmd_bytes_sent", 32'(exp_tx.size()), 0);
        repeat (2) step();
        arst_n = 1'b1;
        repeat (2) step();
        issue(1'b1, 1'b0, 14'h3001, 24'h800001, 0, 24'h0, 0, 0, 6);

        // randomized traffic with random TX backpressure and RX gaps
        bp_rand = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                issue(1'b1, 1'($urandom()), 14'($urandom()), 24'($urandom()),
                      0, 24'h0, 0, 0, -1);
            end else begin
                issue(1'b0, 1'($urandom()), 14'($urandom()), 24'h0,
                      3, 24'($urandom()), 4, 0, -1);
            end
        end
        bp_rand = 1'b0;
        repeat (3) step();
        chk("tx_queue_drained", 32'(exp_tx.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_host_master.md
Name: uart_host_master

Overview:
- Host-side initiator for the UART register/memory access protocol: converts a parallel access request into the command byte stream and, for reads, collects the 3-byte response.
- Talks byte-wise to the TX/RX FIFO side of the serial core, in the same FIFO style as the serial core's host port.
- Used in bench/bridge builds (e.g. an on-chip loopback or a second FPGA) to drive the QM-FIR chip's UART slave port.

Parameters:
- TO_W, 20, width of the read-response timeout counter.
- TO_CYC, 20'hFFFFF, clk cycles without a received byte before a read is aborted; must be ≥1.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  high only in IDLE; transfer on req_valid&req_ready
- req_wr  in  1  1=write, 0=read
- req_mem  in  1  1=memory space, 0=register space
- req_addr  in  14  word address
- req_wdata  in  24  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  24  read data, valid with rsp_valid
- rsp_err  out  1  read timeout, valid with rsp_valid
- busy  out  1  state != IDLE
- tx_data  out  8  byte to TX FIFO
- tx_we  out  1  push tx_data
- tx_full  in  1  TX FIFO full
- rx_data  in  8  RX FIFO head (first-word fall-through)
- rx_re  out  1  pop RX FIFO
- rx_empty  in  1  RX FIFO empty

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; tx_we=0; rx_re=0; busy=0; latched request and timeout counter 0. Reset mid-transfer aborts immediately. No partial response is issued.
- Wire format: byte0={wr,mem,addr[13:8]}, byte1=addr[7:0]. A write then sends 3 data bytes, MSB first. A read receives 3 bytes, MSB first.
- States: IDLE, CMD_HI, CMD_LO, WD2, WD1, WD0, RD2, RD1, RD0, DONE.
- IDLE: req_ready=1. On acceptance, latch wr/mem/addr/wdata and go to CMD_HI. While in IDLE, stale RX bytes are discarded: rx_re=~rx_empty.
- TX states (CMD_HI, CMD_LO, WD2..WD0): tx_data = current byte, combinational from the latched request; tx_we=~tx_full. Advance only on a cycle with tx_we=1.
  - CMD_LO goes to WD2 if wr, else RD2.
  - WD0 goes to DONE.
- RX states (RD2..RD0): rx_re=~rx_empty. On a pop, capture rx_data into rdata[23:16]/[15:8]/[7:0] respectively and advance; RD0 goes to DONE.
- Timeout counter:
  - Cleared on entry to RD2 and on every pop.
  - Increments each RX-state cycle with rx_empty=1.
  - When it reaches TO_CYC-1 with still no byte: go to DONE with err=1 and rdata forced to 0.
- DONE: for one cycle, rsp_valid=1, rsp_err=err, rsp_rdata=rdata (0 for writes). Next state IDLE. rsp_* are registered and hold their value until the next DONE.
- Latency (no backpressure):
  - Write: accept at T, tx_we at T+1..T+5, rsp_valid at T+6.
  - Read: bytes at T+1..T+2. If RX bytes are available each cycle, pops at T+3..T+5 and rsp_valid at T+6.
- tx_full stalls hold state and byte, with no duplicate pushes. req_valid is ignored while busy. tx_we and rx_re are never high together.

Decomposition:
- Package qmfir_uart_pkg holds:
  - state encoding constants;
  - protocol constants: WR bit 7 and MEM bit 6 of byte0, ADDR_W=14, DATA_W=24, DATA_BYTES=3.
- The responder is updated to share the package.
- Optional sub-module uart_rsp_timer: a TO_W-bit load/clear/increment counter with terminal-count output. Everything else stays in one module.

Test Plan:
- Write, no backpressure: wr=1, mem=1, addr=14'h0123, wdata=24'hA5B6C7 → tx bytes C1,23,A5,B6,C7 on consecutive cycles; rsp_valid at T+6 with err=0.
- Read register: wr=0, mem=0, addr=14'h3FFF; RX preloaded 12,34,56 → tx bytes 3F,FF; rsp_rdata=24'h123456, err=0; exactly 3 pops.
- Backpressure: tx_full high for 4 cycles during WD1 → no push while full; byte sequence unchanged; rsp_valid delayed by 4 cycles.
- Timeout: TO_CYC=16; read with RX delivering only 1 byte → rsp_valid 16 cycles after the last pop, err=1, rdata=0; then req_ready=1.
- Stale RX flush: 2 bytes in the RX FIFO while IDLE → both popped before the next request; the next read returns only fresh data.
- Reset asserted in RD1 → all outputs return to reset values asynchronously; no rsp_valid; the next request proceeds normally.
